// File: rtl/nla_pkg.sv
// Shared definitions for the non-linear approximation stages: coefficient
// word layout and the saturating adder every stage uses for its final sum.
package nla_pkg;

  // A coefficient word packs two equal-width signed fields.
  function automatic int coef_width(input int data_width);
    return data_width / 2;
  endfunction

  // Field positions inside a coefficient word, in units of coefficient width:
  // slope in the upper half, intercept in the lower half.
  localparam int SLOPE_FIELD = 1;
  localparam int ICPT_FIELD  = 0;

  // Add two signed terms and clamp the sum to the signed range of w bits.
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, separate occupancy count
// and naturally wrapping power-of-two pointers.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop & ~empty;

  // Storage write on push.
  // NOTE: the storage array has no reset; only pointers, count and the head
  // register need a defined value, and leaving the array out keeps it a RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head word.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Head comes from the incoming word when the FIFO is (or becomes) empty
      // before this push; otherwise from the next stored entry on pop.
      if (push && (count == '0 || (do_pop && count == CNT_W'(1))))
        dout <= din;
      else if (do_pop && count > CNT_W'(1))
        dout <= mem[rd_ptr + PTR_W'(1)];
    end
  end

  // Upstream flow control must keep pushes away from a full FIFO.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: rtl/pwl_coef_fetch.sv
// Piecewise-linear evaluator: reads {slope, intercept} from RAM port B,
// computes y = intercept + (slope*offset)>>>OFF_W with saturation and buffers
// results in a credit-protected FIFO so output backpressure never stalls the
// RAM read pipeline.
module pwl_coef_fetch
  import nla_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_LINES = 4,
  parameter  int X_WIDTH    = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int COEF_W     = coef_width(DATA_WIDTH),
  localparam int OFF_W      = X_WIDTH - ADDR_LINES,
  localparam int CRED_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [X_WIDTH-1:0]    x_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  output logic [ADDR_LINES-1:0] ram_addrb_o,
  output logic                  ram_enb_o,
  output logic                  ram_regceb_o,
  output logic                  ram_rstnb_o,
  input  logic [DATA_WIDTH-1:0] ram_doutb_i,
  output logic [COEF_W-1:0]     y_o,
  output logic                  y_valid_o,
  input  logic                  y_ready_i
);

  logic [CRED_W-1:0]           credits;
  logic                        accept;
  logic                        pop;
  logic                        v1;
  logic                        v2;
  logic [OFF_W-1:0]            off1;
  logic [OFF_W-1:0]            off2;
  logic signed [COEF_W-1:0]    slope;
  logic signed [COEF_W-1:0]    icpt;
  logic signed [COEF_W+OFF_W:0] prod;
  logic [COEF_W-1:0]           y_calc;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [CRED_W-1:0]           fifo_count;

  // Ready depends only on registered credits, never on y_ready_i.
  assign x_ready_o    = (credits != '0) & ~rst_i;
  assign accept       = x_valid_i & x_ready_o;
  assign ram_addrb_o  = x_i[X_WIDTH-1 -: ADDR_LINES];
  assign ram_enb_o    = accept;
  assign ram_regceb_o = v1;
  assign ram_rstnb_o  = ~rst_i;
  assign y_valid_o    = ~fifo_empty;
  assign pop          = y_valid_o & y_ready_i;

  // One credit per FIFO slot: spent on accept, returned on pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits <= CRED_W'(FIFO_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Offset travels alongside the two-cycle RAM read (address, then output reg).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      off1 <= '0;
      off2 <= '0;
    end else begin
      v1   <= accept;
      v2   <= v1;
      if (accept) off1 <= x_i[OFF_W-1:0];
      off2 <= off1;
    end
  end

  // Linear evaluation on the registered RAM word; floor shift then saturate.
  // NOTE: every variable written here is assigned on every pass through the
  // block, so no latch can be inferred.
  always_comb begin
    slope  = ram_doutb_i[SLOPE_FIELD*COEF_W +: COEF_W];
    icpt   = ram_doutb_i[ICPT_FIELD*COEF_W +: COEF_W];
    prod   = slope * $signed({1'b0, off2});
    y_calc = COEF_W'(sat_add(longint'(icpt), longint'(prod) >>> OFF_W, COEF_W));
  end

  sync_fifo #(
    .WIDTH (COEF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (v2),
    .pop   (pop),
    .din   (y_calc),
    .dout  (y_o),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Every slot is either a credit, a sample in flight, or a stored result.
  a_credit_balance: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(credits) + int'(fifo_count) + int'(v1) + int'(v2) == FIFO_DEPTH);
  a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i) !(v2 && fifo_full));

endmodule

// File: tb/tb_pwl_coef_fetch.sv
// Self-checking bench for pwl_coef_fetch: RAM port-B model, behavioural
// result model with timestamps, per-cycle compare process, directed cases.
module tb_pwl_coef_fetch;

  localparam int DW = 32;
  localparam int AL = 4;
  localparam int XW = 16;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk_i     = 1'b0;
  logic          rst_i     = 1'b0;
  logic [XW-1:0] x_i       = '0;
  logic          x_valid_i = 1'b0;
  logic          y_ready_i = 1'b0;
  logic          x_ready_o;
  logic [AL-1:0] ram_addrb_o;
  logic          ram_enb_o;
  logic          ram_regceb_o;
  logic          ram_rstnb_o;
  logic [DW-1:0] ram_doutb;
  logic [CW-1:0] y_o;
  logic          y_valid_o;

  logic [DW-1:0] tbl [16];
  logic [DW-1:0] ram_lat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mcred = FD;
  bit prev_acc   = 1'b0;
  bit prev_stall = 1'b0;
  logic [CW-1:0] prev_y = '0;

  typedef struct {
    logic [CW-1:0] val;
    int            rdy;
  } exp_t;
  exp_t mq[$];

  always #5 clk_i = ~clk_i;

  pwl_coef_fetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .x_i          (x_i),
    .x_valid_i    (x_valid_i),
    .x_ready_o    (x_ready_o),
    .ram_addrb_o  (ram_addrb_o),
    .ram_enb_o    (ram_enb_o),
    .ram_regceb_o (ram_regceb_o),
    .ram_rstnb_o  (ram_rstnb_o),
    .ram_doutb_i  (ram_doutb),
    .y_o          (y_o),
    .y_valid_o    (y_valid_o),
    .y_ready_i    (y_ready_i)
  );

  // RAM port B: read latch, then output register with its own reset.
  always @(posedge clk_i) if (ram_enb_o) ram_lat <= tbl[ram_addrb_o];
  always @(posedge clk_i or negedge ram_rstnb_o)
    if (!ram_rstnb_o)      ram_doutb <= '0;
    else if (ram_regceb_o) ram_doutb <= ram_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y = clamp(intercept + floor(slope*offset / 2^12)) in plain integers.
  function automatic logic [CW-1:0] pwl_model(input logic [DW-1:0] word, input logic [XW-1:0] x);
    longint slope, icpt, off, r;
    logic [63:0] rv;
    slope = longint'($signed(word[31:16]));
    icpt  = longint'($signed(word[15:0]));
    off   = longint'(x[11:0]);
    r     = icpt + ((slope * off) >>> 12);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    rv = r;
    return rv[15:0];
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      mq.delete();
      mcred      = FD;
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
      check("rst_y_valid", y_valid_o, 0);
      check("rst_x_ready", x_ready_o, 0);
      check("rst_rstnb", ram_rstnb_o, 0);
      check("rst_enb", ram_enb_o, 0);
      check("rst_regceb", ram_regceb_o, 0);
    end else begin
      bit exp_v;
      bit acc;
      bit pp;
      exp_v = (mq.size() != 0) && (mq[0].rdy <= cyc);
      check("y_valid", y_valid_o, exp_v);
      if (exp_v)      check("y_data", y_o, mq[0].val);
      if (prev_stall) check("y_hold", y_o, prev_y);
      check("x_ready", x_ready_o, mcred != 0);
      check("regceb", ram_regceb_o, prev_acc);
      check("rstnb", ram_rstnb_o, 1);
      acc = x_valid_i && x_ready_o;
      check("enb", ram_enb_o, acc);
      if (acc) check("addrb", ram_addrb_o, x_i[15:12]);
      pp = y_valid_o && y_ready_i;
      if (pp && mq.size() != 0) begin
        void'(mq.pop_front());
        mcred++;
      end
      if (acc) begin
        mq.push_back('{pwl_model(tbl[x_i[15:12]], x_i), cyc + 3});
        mcred--;
      end
      prev_acc   = acc;
      prev_stall = y_valid_o && !y_ready_i;
      prev_y     = y_o;
    end
  end

  task automatic directed(input string name, input int idx, input logic [DW-1:0] word,
                          input logic [XW-1:0] x, input logic [CW-1:0] exp_y);
    int k;
    tbl[idx] = word;
    @(posedge clk_i); #1;
    y_ready_i = 1'b1;
    x_i       = x;
    x_valid_i = 1'b1;
    @(negedge clk_i);
    check({name, "_acc"}, x_ready_o, 1);
    @(posedge clk_i); #1;
    x_valid_i = 1'b0;
    k = 1;
    @(negedge clk_i);
    while (!y_valid_o && k < 10) begin
      @(negedge clk_i);
      k++;
    end
    check({name, "_latency"}, k, 3);
    check({name, "_y"}, y_o, exp_y);
    @(posedge clk_i); #1;
  endtask

  task automatic drain(input string name);
    int k;
    @(posedge clk_i); #1;
    x_valid_i = 1'b0;
    y_ready_i = 1'b1;
    k = 0;
    while (mq.size() != 0 && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    check({name, "_drained"}, mq.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  // Stall the output, offer 8 samples, expect exactly FD accepted.
  task automatic fill_check(input string name);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      y_ready_i = 1'b0;
      x_valid_i = 1'b1;
      x_i       = 16'($urandom);
      @(negedge clk_i);
      if (x_ready_o) acc++;
    end
    check({name, "_accepts"}, acc, FD);
    check({name, "_blocked"}, x_ready_o, 0);
    @(posedge clk_i); #1;
    x_valid_i = 1'b0;
    y_ready_i = 1'b1;
    @(negedge clk_i);
    check({name, "_still_blocked"}, x_ready_o, 0);
    @(negedge clk_i);
    check({name, "_resumed"}, x_ready_o, 1);
    drain(name);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) tbl[i] = $urandom;

    // Hand-computed anchors for the model itself.
    check("model_basic", pwl_model(32'h0100_0010, 16'h3800), 16'h0090);
    check("model_neg", pwl_model(32'hFF00_0000, 16'h5800), 16'hFF80);
    check("model_floor", pwl_model(32'hFFFF_0005, 16'h5001), 16'h0004);
    check("model_sat_hi", pwl_model(32'h7FFF_7FFF, 16'hFFFF), 16'h7FFF);
    check("model_sat_lo", pwl_model(32'h8000_8000, 16'hFFFF), 16'h8000);

    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_y_o", y_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_x_ready", x_ready_o, 1);
    check("post_rst_y_o", y_o, 0);

    directed("e3", 3, 32'h0100_0010, 16'h3800, 16'h0090);
    directed("e5a", 5, 32'hFF00_0000, 16'h5800, 16'hFF80);
    directed("e5b", 5, 32'hFFFF_0005, 16'h5001, 16'h0004);
    directed("e15a", 15, 32'h7FFF_7FFF, 16'hFFFF, 16'h7FFF);
    directed("e15b", 15, 32'h8000_8000, 16'hFFFF, 16'h8000);
    drain("directed");

    fill_check("bp");

    // Randomized valid/ready traffic against the model.
    for (int i = 0; i < 16; i++) tbl[i] = $urandom;
    n = 0;
    for (int c = 0; c < 30000 && n < 1000; c++) begin
      @(posedge clk_i); #1;
      x_valid_i = ($urandom_range(3) != 0);
      x_i       = 16'($urandom);
      y_ready_i = ($urandom_range(2) != 0);
      @(negedge clk_i);
      if (x_valid_i && x_ready_o) n++;
    end
    check("rand_accepts", n, 1000);
    drain("rand");

    // Reset with two results stored and two samples in flight.
    @(posedge clk_i); #1;
    y_ready_i = 1'b0;
    x_valid_i = 1'b1;
    x_i       = 16'h1234;
    @(posedge clk_i); #1;
    x_i       = 16'hA5A5;
    @(posedge clk_i); #1;
    x_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("pre_rst_valid", y_valid_o, 1);
    x_valid_i = 1'b1;
    x_i       = 16'h7777;
    @(posedge clk_i); #1;
    x_i       = 16'hC3C3;
    @(posedge clk_i); #1;
    x_valid_i = 1'b0;
    rst_i     = 1'b1;
    #1;
    check("mid_rst_valid", y_valid_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    y_ready_i = 1'b1;
    @(negedge clk_i);
    check("rel_x_ready", x_ready_o, 1);
    repeat (10) @(negedge clk_i);
    fill_check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
